// File: rtl/accum_sequencer_if.sv
// Command and response channels of the accumulator sequencer.
// master drives commands and consumes responses; slave is the sequencer.
interface accum_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ATTR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [ATTR_WIDTH-1:0] cmd_attr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [7:0]            rsp_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_attr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_attr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_count
  );
endinterface

// File: rtl/accum_sequencer.sv
// Command-driven strobe sequencer for the 8-bit accumulator datapath: turns
// INIT/ADD/SUB/READ commands into timed init/load/neg/oe strobes and returns READ results.
module accum_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ATTR_WIDTH  = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  accum_sequencer_if.slave      bus,
  output logic                  signal_init,
  output logic                  signal_load,
  output logic                  signal_neg,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOAD = 3'd2,
    S_OE   = 3'd3,
    S_WAIT = 3'd4,
    S_RESP = 3'd5
  } state_e;

  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_CYCLES - 1);
  localparam logic [2:0] WAIT_RELOAD = 3'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_e                state_q;
  logic                  init_q, load_q, neg_q, oe_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [7:0]            rsp_count_q;
  logic [7:0]            op_cnt_q;
  logic [3:0]            load_left_q;
  logic [2:0]            wait_left_q;

  // Handshakes: a transfer happens on an edge where valid && ready are both high;
  // valid holds its payload until then, and cmd_ready depends on state alone.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_count = rsp_count_q;
  assign signal_init   = init_q;
  assign signal_load   = load_q;
  assign signal_neg    = neg_q;
  assign signal_oe     = oe_q;
  assign data_in       = data_q;
  assign attr_in       = attr_q;
  assign dbg_state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      load_q      <= 1'b0;
      neg_q       <= 1'b0;
      oe_q        <= 1'b0;
      data_q      <= '0;
      attr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
      op_cnt_q    <= '0;
      load_left_q <= '0;
      wait_left_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_INIT: begin
                init_q   <= 1'b1;
                op_cnt_q <= '0;
                state_q  <= S_INIT;
              end
              OP_ADD, OP_SUB: begin
                load_q      <= 1'b1;
                neg_q       <= (bus.cmd_op == OP_SUB);
                data_q      <= bus.cmd_data;
                attr_q      <= bus.cmd_attr;
                load_left_q <= LOAD_RELOAD;
                if (op_cnt_q != 8'hFF) op_cnt_q <= op_cnt_q + 8'd1;
                state_q     <= S_LOAD;
              end
              default: begin
                oe_q    <= 1'b1;
                state_q <= S_OE;
              end
            endcase
          end
        end
        S_INIT: begin
          init_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_LOAD: begin
          if (load_left_q == 4'd0) begin
            load_q  <= 1'b0;
            neg_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            load_left_q <= load_left_q - 4'd1;
          end
        end
        S_OE: begin
          oe_q <= 1'b0;
          // With zero read latency the result is already valid while oe is high.
          if (RD_LAT == 0) begin
            rsp_data_q  <= result_in;
            rsp_count_q <= op_cnt_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_left_q <= WAIT_RELOAD;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_left_q == 3'd0) begin
            rsp_data_q  <= result_in;
            rsp_count_q <= op_cnt_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_left_q <= wait_left_q - 3'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: directed and random commands against a cycle-level
// expectation model, plus a LOAD_CYCLES=1 / RD_LAT=0 build.
module tb_accum_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LC = 2;
  localparam int RL = 1;
  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main DUT ----------------
  accum_sequencer_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) sif ();
  logic          signal_init, signal_load, signal_neg, signal_oe;
  logic [DW-1:0] data_in, result_in;
  logic [AW-1:0] attr_in;
  logic [2:0]    dbg_state;

  accum_sequencer #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .LOAD_CYCLES(LC), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .bus(sif),
    .signal_init(signal_init), .signal_load(signal_load), .signal_neg(signal_neg),
    .signal_oe(signal_oe), .data_in(data_in), .attr_in(attr_in),
    .result_in(result_in), .dbg_state(dbg_state)
  );

  // Datapath stand-in: one add/sub per load pulse, result valid only RL cycles after oe.
  logic [DW-1:0] dp_acc   = 8'h5A;
  logic          dp_ld_d  = 1'b0;
  logic [7:0]    oe_hist  = 8'h00;
  logic [DW-1:0] junk     = 8'h01;
  logic [8:0]    oe_line;
  always @(posedge clk) begin
    if (signal_init) dp_acc <= '0;
    else if (signal_load && !dp_ld_d) dp_acc <= signal_neg ? dp_acc - data_in : dp_acc + data_in;
    dp_ld_d <= signal_load;
    oe_hist <= {oe_hist[6:0], signal_oe};
    junk    <= 8'($urandom_range(1, 255));
  end
  assign oe_line   = {oe_hist, signal_oe};
  assign result_in = oe_line[RL] ? dp_acc : (dp_acc ^ junk);

  // rsp_ready policy: 0 hold low, 1 hold high, 2 random
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    sif.rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] model_acc = 8'h5A;
  int            model_cnt = 0;
  logic [15:0]   exp_q[$];
  logic          have_op   = 1'b0;
  logic [1:0]    last_op   = OP_INIT;
  int            acc_cyc   = 0;
  logic [DW-1:0] exp_data  = '0;
  logic [AW-1:0] exp_attr  = '0;
  int            reads_issued = 0;
  int            hs_count  = 0;
  int            hs_cyc    = 0;
  logic [DW-1:0] last_rsp_data  = '0;
  logic [7:0]    last_rsp_count = '0;
  logic          mon_en    = 1'b0;

  // Per-cycle expectations derived from the last accepted command and its age.
  always @(negedge clk) begin : mon
    int   d;
    logic is_ls;
    logic e_ready;
    logic rd_done;
    if (mon_en) begin
      d       = cyc - acc_cyc;
      is_ls   = have_op && (last_op == OP_ADD || last_op == OP_SUB);
      rd_done = (hs_count == reads_issued);
      chk("signal_init", 32'(signal_init), 32'(have_op && last_op == OP_INIT && d == 0));
      chk("signal_load", 32'(signal_load), 32'(is_ls && d < LC));
      chk("signal_neg",  32'(signal_neg),  32'(have_op && last_op == OP_SUB && d < LC));
      chk("signal_oe",   32'(signal_oe),   32'(have_op && last_op == OP_READ && d == 0));
      chk("data_in", 32'(data_in), 32'(exp_data));
      chk("attr_in", 32'(attr_in), 32'(exp_attr));
      if (!have_op)                e_ready = 1'b1;
      else if (last_op == OP_INIT) e_ready = (d >= 1);
      else if (is_ls)              e_ready = (d >= LC);
      else                         e_ready = rd_done;
      chk("cmd_ready", 32'(sif.cmd_ready), 32'(e_ready));
      chk("rsp_valid", 32'(sif.rsp_valid),
          32'(have_op && last_op == OP_READ && !rd_done && d >= 1 + RL));
      if (sif.rsp_valid) begin
        chk("rsp_pending", 32'(hs_count < exp_q.size()), 32'd1);
        if (hs_count < exp_q.size()) begin
          chk("rsp_data",  32'(sif.rsp_data),  32'(exp_q[hs_count][15:8]));
          chk("rsp_count", 32'(sif.rsp_count), 32'(exp_q[hs_count][7:0]));
        end
        if (sif.rsp_ready) begin
          last_rsp_data  = sif.rsp_data;
          last_rsp_count = sif.rsp_count;
          hs_cyc         = cyc;
          hs_count       = hs_count + 1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a);
    int budget;
    budget = 0;
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = op;
    sif.cmd_data  = d;
    sif.cmd_attr  = a;
    @(negedge clk);
    while (!sif.cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("accept_timeout", 32'(budget < 200), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    last_op = op;
    have_op = 1'b1;
    case (op)
      OP_INIT: begin model_acc = '0; model_cnt = 0; end
      OP_ADD, OP_SUB: begin
        model_acc = (op == OP_ADD) ? model_acc + d : model_acc - d;
        model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
        exp_data  = d;
        exp_attr  = a;
      end
      default: begin
        exp_q.push_back({model_acc, 8'(model_cnt)});
        reads_issued++;
      end
    endcase
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = 2'($urandom);
    sif.cmd_data  = 8'($urandom);
    sif.cmd_attr  = 4'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (hs_count != reads_issued && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_timeout", 32'(budget < 200), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- second build: LOAD_CYCLES=1, RD_LAT=0 ----------------
  accum_sequencer_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) bif ();
  logic          b_init, b_load, b_neg, b_oe;
  logic [DW-1:0] b_data_in, b_result;
  logic [AW-1:0] b_attr;
  logic [2:0]    b_state;
  int            b_acc_cyc = 0;

  accum_sequencer #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .LOAD_CYCLES(1), .RD_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bif),
    .signal_init(b_init), .signal_load(b_load), .signal_neg(b_neg),
    .signal_oe(b_oe), .data_in(b_data_in), .attr_in(b_attr),
    .result_in(b_result), .dbg_state(b_state)
  );

  logic [DW-1:0] b_acc   = '0;
  logic          b_ld_d  = 1'b0;
  always @(posedge clk) begin
    if (b_init) b_acc <= '0;
    else if (b_load && !b_ld_d) b_acc <= b_neg ? b_acc - b_data_in : b_acc + b_data_in;
    b_ld_d <= b_load;
  end
  assign b_result = b_oe ? b_acc : ~b_acc;

  task automatic send_b(input logic [1:0] op, input logic [DW-1:0] d);
    int budget;
    budget = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_data  = d;
    bif.cmd_attr  = 4'h3;
    @(negedge clk);
    while (!bif.cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("b_accept_timeout", 32'(budget < 50), 32'd1);
    @(posedge clk);
    #1;
    b_acc_cyc     = cyc;
    bif.cmd_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev;
    sif.cmd_valid = 1'b0; sif.cmd_op = '0; sif.cmd_data = '0; sif.cmd_attr = '0;
    bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_data = '0; bif.cmd_attr = '0;
    bif.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_rsp_data",  32'(sif.rsp_data),  32'd0);
    chk("rst_rsp_count", 32'(sif.rsp_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // READ before any INIT returns the datapath's power-up value with count 0
    send(OP_READ, '0, '0);
    drain();
    chk("pre_init_count", 32'(last_rsp_count), 32'd0);

    // INIT, ADD 4, ADD 3, SUB 5, READ -> 2 with three ops counted
    send(OP_INIT, '0, '0);
    send(OP_ADD, 8'd4, 4'h1);
    send(OP_ADD, 8'd3, 4'h2);
    send(OP_SUB, 8'd5, 4'h3);
    send(OP_READ, '0, '0);
    drain();
    chk("plan_data",  32'(last_rsp_data),  32'd2);
    chk("plan_count", 32'(last_rsp_count), 32'd3);

    // back-to-back ADD 2 with valid kept high: one accept every LC+1 cycles
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(OP_ADD, 8'd2, 4'h5);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev), 32'(LC + 1));
      prev = acc_cyc;
    end

    // response stalled 5+ cycles while ADD 9 waits on the command port
    rdy_mode = 0;
    send(OP_READ, '0, '0);
    fork
      begin
        int b;
        b = 0;
        while (!sif.rsp_valid && b < 100) begin
          @(negedge clk);
          b++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
      send(OP_ADD, 8'd9, 4'h9);
    join
    chk("stall_accept", 32'(acc_cyc - hs_cyc), 32'd2);

    // reset in the first cycle of an ADD load window
    send(OP_ADD, 8'($urandom_range(0, 255)), 4'hA);
    rst = 1'b1;
    @(posedge clk);
    #1;
    have_op = 1'b0; exp_data = '0; exp_attr = '0; model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(OP_READ, '0, '0);
    drain();
    chk("rst_count", 32'(last_rsp_count), 32'd0);

    // counter saturation, then cleared by INIT
    send(OP_INIT, '0, '0);
    for (int i = 0; i < 300; i++) send(OP_ADD, 8'd1, 4'h0);
    send(OP_READ, '0, '0);
    drain();
    chk("sat_count", 32'(last_rsp_count), 32'd255);
    chk("sat_data",  32'(last_rsp_data),  32'd44);
    send(OP_INIT, '0, '0);
    send(OP_READ, '0, '0);
    drain();
    chk("init_count", 32'(last_rsp_count), 32'd0);
    chk("init_data",  32'(last_rsp_data),  32'd0);

    // random commands with random response back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 80; i++)
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    rdy_mode = 1;
    drain();

    // LOAD_CYCLES=1, RD_LAT=0 build
    send_b(OP_INIT, '0);
    prev = b_acc_cyc;
    for (int i = 0; i < 3; i++) begin
      send_b(OP_ADD, 8'd7);
      chk("b_spacing", 32'(b_acc_cyc - prev), 32'd2);
      prev = b_acc_cyc;
      @(negedge clk);
      chk("b_load", 32'(b_load), 32'd1);
    end
    send_b(OP_READ, '0);
    @(negedge clk);
    chk("b_oe",          32'(b_oe),          32'd1);
    chk("b_rsp_early",   32'(bif.rsp_valid), 32'd0);
    @(negedge clk);
    chk("b_rsp_valid",   32'(bif.rsp_valid), 32'd1);
    chk("b_rsp_data",    32'(bif.rsp_data),  32'd21);
    chk("b_rsp_count",   32'(bif.rsp_count), 32'd3);
    @(negedge clk);
    chk("b_rsp_cleared", 32'(bif.rsp_valid), 32'd0);
    chk("b_ready",       32'(bif.cmd_ready), 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Command-driven controller for the 8-bit accumulator datapath. Accepts INIT/ADD/SUB/READ commands over a valid/ready handshake and emits the datapath strobes (signal_init, signal_load, signal_neg, signal_oe) with correct widths and data hold times. On READ it captures the datapath result and returns it on a valid/ready response port. It replaces hand-timed strobe sequences and is the single owner of the accumulator's control pins.

Parameters:
DATA_WIDTH, 8, operand and result width
ATTR_WIDTH, 4, attribute field width, passed through to the datapath
LOAD_CYCLES, 2, cycles signal_load (and signal_neg) stay high per ADD/SUB; legal range 1..15
RD_LAT, 1, cycles from signal_oe high to result_in valid; legal range 0..7

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer accepts command this cycle
cmd_op  in  2  00 INIT, 01 ADD, 10 SUB, 11 READ
cmd_data  in  DATA_WIDTH  operand for ADD/SUB; ignored otherwise
cmd_attr  in  ATTR_WIDTH  attribute for ADD/SUB
rsp_valid  out  1  READ result available
rsp_ready  in  1  consumer takes result
rsp_data  out  DATA_WIDTH  captured accumulator value
rsp_count  out  8  ADD+SUB operations since last INIT, saturating
signal_init  out  1  datapath clear strobe
signal_load  out  1  datapath load strobe
signal_neg  out  1  datapath negate-operand qualifier
signal_oe  out  1  datapath output enable
data_in  out  DATA_WIDTH  operand to datapath
attr_in  out  ATTR_WIDTH  attribute to datapath
result_in  in  DATA_WIDTH  accumulator output from datapath

Behaviour:
- Reset (rst high at edge): state IDLE; all strobes, rsp_valid, rsp_data, rsp_count, data_in, attr_in, internal op counter = 0. Reset overrides any in-flight op; strobes drop at the first edge with rst high, with no partial completion.
- All outputs registered. cmd_ready = (state == IDLE); combinational from state only, never from cmd_valid.
- States: IDLE, INIT, LOAD, OE, WAIT, RESP.
- Accept on edge T when cmd_valid && cmd_ready; op/data/attr registered at T; operation strobes start in cycle T+1.
- INIT: signal_init high for exactly cycle T+1; op counter cleared at the same edge; back to IDLE; cmd_ready high in T+2.
- ADD: data_in/attr_in driven from T+1 and held until the next ADD/SUB accept (not cleared). signal_load high cycles T+1..T+LOAD_CYCLES, signal_neg low. Counter increments once per op, saturating at 255. cmd_ready high in T+LOAD_CYCLES+1.
- SUB: as ADD, with signal_neg high over exactly the same cycles as signal_load.
- READ: signal_oe high for cycle T+1 only. WAIT for RD_LAT cycles (skipped if RD_LAT = 0). result_in sampled at the end of cycle T+1+RD_LAT into rsp_data; rsp_count latches the counter at the same edge. rsp_valid goes high from T+2+RD_LAT (state RESP).
- RESP: rsp_valid, rsp_data and rsp_count are held stable until the edge where rsp_ready is high. rsp_valid clears at that edge and the state returns to IDLE. cmd_ready stays low throughout RESP, so commands stall and no strobe fires.
- Strobes are mutually exclusive: at most one of init/load/oe is high in any cycle.
- cmd_valid may drop or cmd_op may change while cmd_ready is low without effect. Only the accepted command executes.
- READ before any INIT is legal: returns the datapath value, with rsp_count = 0 after reset.
- Counter saturation: once at 255, further ADD/SUB leave it at 255 until INIT or rst.

Test Plan:
- rst 2 cycles, then INIT, ADD 4, ADD 3, SUB 5, READ. Behavioural accumulator model on result_in, RD_LAT = 1 -> rsp_data = 2, rsp_count = 3. signal_load high exactly 2 cycles per ADD/SUB. signal_neg high only during the SUB load window.
- Back-to-back ADD 2 with cmd_valid held high -> accepts spaced every 3 cycles (LOAD_CYCLES+1). data_in = 2 stable during every load window. No gaps or overlaps of strobes.
- READ with rsp_ready low for 5 cycles while an ADD 9 is pending on cmd -> rsp_valid/rsp_data stable for 5 cycles, cmd_ready low, no signal_load. The ADD is accepted in the cycle after the rsp handshake.
- rst asserted in the first cycle of an ADD load window -> signal_load 0 at the next edge, rsp_count 0, cmd_ready 1 in the cycle after rst falls.
- 300 ADD 1 commands then READ -> rsp_count = 255. A following INIT then READ -> rsp_count = 0, signal_init 1-cycle pulse.
- RD_LAT = 0 and LOAD_CYCLES = 1 build: READ -> result_in sampled in the same cycle as signal_oe, rsp_valid one cycle later. ADD throughput of one command every 2 cycles.
